// File: rtl/player_ship.sv
// player_ship: player ship movement, single player shot, lives and
// invulnerability, plus per-slot hit detection against the formation's
// enemy projectile buses. Runs on the clk_4 game-logic domain.
module player_ship #(
  parameter int SHIP_Y        = 450,
  parameter int X_MIN         = 100,
  parameter int X_MAX         = 540,
  parameter int X_START       = 320,
  parameter int MOVE_DIV      = 4,
  parameter int SHOT_SPEED    = 4,
  parameter int HIT_HALF_W    = 10,
  parameter int LIVES         = 3,
  parameter int INVULN_CYCLES = 65535
) (
  input  logic        clk_4,
  input  logic        clr,
  input  logic        play,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_fire,
  input  logic [45:0] enemy_projectiles_x,
  input  logic [44:0] enemy_projectiles_y,
  input  logic        collision,
  output logic [9:0]  projectiles_x,
  output logic [9:0]  projectiles_y,
  output logic [9:0]  player_x,
  output logic [4:0]  destroy,
  output logic [1:0]  lives,
  output logic        hit,
  output logic        game_over
);

  localparam int DIV_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

  localparam logic [10:0]      Y_LO        = 11'(SHIP_Y - 10);
  localparam logic [10:0]      Y_HI        = 11'(SHIP_Y + 10);
  localparam logic [10:0]      HALF_W      = 11'(HIT_HALF_W);
  localparam logic [9:0]       X_LO        = 10'(X_MIN);
  localparam logic [9:0]       X_HI        = 10'(X_MAX);
  localparam logic [9:0]       X_INIT      = 10'(X_START);
  localparam logic [9:0]       SHOT_Y0     = 10'(SHIP_Y - 10);
  localparam logic [9:0]       SHOT_STEP   = 10'(SHOT_SPEED);
  localparam logic [1:0]       LIVES_INIT  = 2'(LIVES);
  localparam logic [15:0]      INVULN_LOAD = 16'(INVULN_CYCLES);
  localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(MOVE_DIV - 1);

  logic [10:0]      slot_x [5];
  logic [10:0]      slot_y [5];
  logic [10:0]      px_ext;
  logic [4:0]       overlap;
  logic [15:0]      invuln_cnt;
  logic [DIV_W-1:0] move_div;
  logic             fire_q;
  logic             fire_rise;

  assign px_ext    = {1'b0, player_x};
  assign fire_rise = btn_fire & ~fire_q;

  // Unpack the enemy slot buses and test each active slot against the ship hitbox.
  // NOTE: every signal driven here is assigned on every pass, so no latch is inferred.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      slot_x[k] = {2'b00, enemy_projectiles_x[9*k +: 9]};
    end
    slot_x[4] = {1'b0, enemy_projectiles_x[45:36]};
    for (int k = 0; k < 5; k++) begin
      slot_y[k]  = {2'b00, enemy_projectiles_y[9*k +: 9]};
      overlap[k] = (slot_y[k] != '0) &&
                   (slot_y[k] >= Y_LO) && (slot_y[k] <= Y_HI) &&
                   (slot_x[k] + HALF_W > px_ext) &&
                   (slot_x[k] < px_ext + HALF_W);
    end
  end

  // All game state: movement, shot, destroy/hit, lives and invulnerability.
  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_4 or posedge clr) begin
    if (clr) begin
      player_x      <= X_INIT;
      lives         <= LIVES_INIT;
      projectiles_x <= '0;
      projectiles_y <= '0;
      destroy       <= '0;
      hit           <= 1'b0;
      game_over     <= 1'b0;
      invuln_cnt    <= '0;
      move_div      <= '0;
      fire_q        <= 1'b0;
    end else if (!play) begin
      player_x      <= X_INIT;
      lives         <= LIVES_INIT;
      projectiles_x <= '0;
      projectiles_y <= '0;
      destroy       <= '0;
      hit           <= 1'b0;
      game_over     <= 1'b0;
      invuln_cnt    <= '0;
      move_div      <= '0;
      fire_q        <= 1'b0;
    end else if (game_over) begin
      // Frozen until play drops: no shot, no kills, buttons ignored.
      projectiles_x <= '0;
      projectiles_y <= '0;
      destroy       <= '0;
      hit           <= 1'b0;
      fire_q        <= btn_fire;
    end else begin
      // Ship steps one pixel each time the divider wraps.
      if (move_div == DIV_LAST) begin
        move_div <= '0;
        if (btn_left && !btn_right && (player_x > X_LO)) begin
          player_x <= player_x - 10'd1;
        end else if (btn_right && !btn_left && (player_x < X_HI)) begin
          player_x <= player_x + 10'd1;
        end
      end else begin
        move_div <= move_div + DIV_W'(1);
      end

      // Single shot: load only when idle, so a fire edge in flight is dropped.
      fire_q <= btn_fire;
      if (fire_rise && (projectiles_y == '0)) begin
        projectiles_x <= player_x;
        projectiles_y <= SHOT_Y0;
      end else if (projectiles_y != '0) begin
        if (collision || (projectiles_y <= SHOT_STEP)) begin
          projectiles_y <= '0;
        end else begin
          projectiles_y <= projectiles_y - SHOT_STEP;
        end
      end

      // Projectiles are absorbed even while invulnerable; only RUN costs a life.
      destroy <= overlap;
      hit     <= 1'b0;
      if ((invuln_cnt == '0) && (overlap != '0)) begin
        lives      <= lives - 2'd1;
        hit        <= 1'b1;
        invuln_cnt <= INVULN_LOAD;
        if (lives == 2'd1) begin
          game_over <= 1'b1;
        end
      end else if (invuln_cnt != '0) begin
        invuln_cnt <= invuln_cnt - 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_player_ship.sv
// tb_player_ship: directed steps plus a randomized phase, every cycle checked
// against a behavioural model of the ship rules kept in plain integers.
module tb_player_ship;

  localparam int SHIP_Y        = 450;
  localparam int X_MIN         = 100;
  localparam int X_MAX         = 540;
  localparam int X_START       = 320;
  localparam int MOVE_DIV      = 4;
  localparam int SHOT_SPEED    = 4;
  localparam int HIT_HALF_W    = 10;
  localparam int LIVES         = 3;
  localparam int INVULN_CYCLES = 300;

  logic        clk_4 = 1'b0;
  logic        clr, play, btn_left, btn_right, btn_fire, collision;
  logic [45:0] ex_bus;
  logic [44:0] ey_bus;
  logic [9:0]  projectiles_x, projectiles_y, player_x;
  logic [4:0]  destroy;
  logic [1:0]  lives;
  logic        hit, game_over;

  int checks   = 0;
  int failures = 0;

  // Enemy slot positions as plain integers; packed onto the buses each step.
  int e_x [5];
  int e_y [5];

  // Reference model state.
  int         m_px, m_sx, m_sy, m_lives, m_inv, m_cyc;
  bit         m_over, m_fprev, m_hit;
  logic [4:0] m_destroy;

  player_ship #(
    .SHIP_Y(SHIP_Y), .X_MIN(X_MIN), .X_MAX(X_MAX), .X_START(X_START),
    .MOVE_DIV(MOVE_DIV), .SHOT_SPEED(SHOT_SPEED), .HIT_HALF_W(HIT_HALF_W),
    .LIVES(LIVES), .INVULN_CYCLES(INVULN_CYCLES)
  ) dut (
    .clk_4(clk_4), .clr(clr), .play(play),
    .btn_left(btn_left), .btn_right(btn_right), .btn_fire(btn_fire),
    .enemy_projectiles_x(ex_bus), .enemy_projectiles_y(ey_bus),
    .collision(collision),
    .projectiles_x(projectiles_x), .projectiles_y(projectiles_y),
    .player_x(player_x), .destroy(destroy), .lives(lives),
    .hit(hit), .game_over(game_over)
  );

  always #5 clk_4 = ~clk_4;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reinit();
    m_px = X_START; m_lives = LIVES; m_sx = 0; m_sy = 0;
    m_destroy = '0; m_hit = 1'b0; m_over = 1'b0;
    m_inv = 0; m_cyc = 0; m_fprev = 1'b0;
  endtask

  task automatic clear_slots();
    for (int k = 0; k < 5; k++) begin
      e_x[k] = 0;
      e_y[k] = 0;
    end
  endtask

  task automatic drive_slots();
    for (int k = 0; k < 4; k++) ex_bus[9*k +: 9] = 9'(e_x[k]);
    ex_bus[45:36] = 10'(e_x[4]);
    for (int k = 0; k < 5; k++) ey_bus[9*k +: 9] = 9'(e_y[k]);
  endtask

  // Advance the model by one clock from the current inputs.
  task automatic model_next();
    logic [4:0] ov;
    int         old_px;
    if (!play) begin
      model_reinit();
      return;
    end
    if (m_over) begin
      m_sx = 0; m_sy = 0; m_destroy = '0; m_hit = 1'b0;
      m_fprev = btn_fire;
      return;
    end
    // A slot hits when it is in the ship's row band and within half-width in x.
    for (int k = 0; k < 5; k++) begin
      ov[k] = (e_y[k] != 0) && (e_y[k] >= SHIP_Y - 10) && (e_y[k] <= SHIP_Y + 10) &&
              (e_x[k] - m_px < HIT_HALF_W) && (m_px - e_x[k] < HIT_HALF_W);
    end
    old_px = m_px;
    // One pixel per MOVE_DIV cycles of running time.
    if ((m_cyc % MOVE_DIV) == MOVE_DIV - 1) begin
      if (btn_left && !btn_right)      m_px = (m_px - 1 < X_MIN) ? X_MIN : m_px - 1;
      else if (btn_right && !btn_left) m_px = (m_px + 1 > X_MAX) ? X_MAX : m_px + 1;
    end
    m_cyc++;
    if (btn_fire && !m_fprev && m_sy == 0) begin
      m_sx = old_px;
      m_sy = SHIP_Y - 10;
    end else if (m_sy != 0) begin
      m_sy = (collision || m_sy <= SHOT_SPEED) ? 0 : m_sy - SHOT_SPEED;
    end
    m_fprev   = btn_fire;
    m_destroy = ov;
    m_hit     = 1'b0;
    if (ov != 0 && m_inv == 0) begin
      m_lives--;
      m_hit = 1'b1;
      m_inv = INVULN_CYCLES;
      if (m_lives == 0) m_over = 1'b1;
    end else if (m_inv > 0) begin
      m_inv--;
    end
  endtask

  task automatic check_all();
    check("player_x", 32'(player_x), m_px);
    check("projectiles_x", 32'(projectiles_x), m_sx);
    check("projectiles_y", 32'(projectiles_y), m_sy);
    check("lives", 32'(lives), m_lives);
    check("destroy", 32'(destroy), 32'(m_destroy));
    check("hit", 32'(hit), 32'(m_hit));
    check("game_over", 32'(game_over), 32'(m_over));
  endtask

  // Inputs are changed 1 time unit after an edge; outputs sampled 1 after the next.
  task automatic step();
    drive_slots();
    model_next();
    @(posedge clk_4);
    #1;
    check_all();
  endtask

  initial begin
    int r;
    clr = 1'b0; play = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
    btn_fire = 1'b0; collision = 1'b0;
    clear_slots();
    drive_slots();
    model_reinit();

    // Reset.
    #1 clr = 1'b1;
    #2;
    check("rst_player_x", 32'(player_x), 320);
    check("rst_lives", 32'(lives), 3);
    check("rst_proj_y", 32'(projectiles_y), 0);
    check("rst_proj_x", 32'(projectiles_x), 0);
    check("rst_destroy", 32'(destroy), 0);
    check("rst_hit_go", {30'd0, hit, game_over}, 0);
    @(posedge clk_4);
    #1;
    clr  = 1'b0;
    play = 1'b1;

    // Movement and clamp.
    btn_right = 1'b1;
    repeat (40) step();
    check("move_right_40", 32'(player_x), 330);
    btn_right = 1'b0; btn_left = 1'b1;
    repeat (916) step();
    check("move_left_to_101", 32'(player_x), 101);
    repeat (20) step();
    check("clamp_x_min", 32'(player_x), 100);
    btn_left = 1'b0; btn_right = 1'b1;
    repeat (880) step();
    check("back_to_320", 32'(player_x), 320);
    btn_right = 1'b0;

    // Fire and travel.
    btn_fire = 1'b1; step();
    check("shot_load_x", 32'(projectiles_x), 320);
    check("shot_load_y", 32'(projectiles_y), 440);
    btn_fire = 1'b0; step();
    check("shot_y_436", 32'(projectiles_y), 436);
    step();
    check("shot_y_432", 32'(projectiles_y), 432);
    btn_fire = 1'b1; step();
    check("refire_dropped", 32'(projectiles_y), 428);
    btn_fire = 1'b0;
    repeat (7) step();
    check("shot_y_400", 32'(projectiles_y), 400);
    collision = 1'b1; step();
    check("collision_clear", 32'(projectiles_y), 0);
    collision = 1'b0;

    // First hit.
    e_x[2] = 325; e_y[2] = 450; step();
    check("hit1_destroy", 32'(destroy), 32'b00100);
    check("hit1_pulse", 32'(hit), 1);
    check("hit1_lives", 32'(lives), 2);
    e_y[2] = 0; step();
    check("hit1_destroy_off", 32'(destroy), 0);
    check("hit1_pulse_off", 32'(hit), 0);

    // Simultaneous overlap after invulnerability ends.
    repeat (INVULN_CYCLES + 5) step();
    e_x[0] = 322; e_y[0] = 445; e_x[4] = 318; e_y[4] = 455; step();
    check("multi_destroy", 32'(destroy), 32'b10001);
    check("multi_lives", 32'(lives), 1);
    clear_slots(); step();
    repeat (100) step();
    e_x[1] = 320; e_y[1] = 450; step();
    check("invuln_destroy", 32'(destroy), 32'b00010);
    check("invuln_lives", 32'(lives), 1);
    check("invuln_no_hit", 32'(hit), 0);
    clear_slots(); step();

    // Hitbox boundaries.
    e_x[3] = 310; e_y[3] = 450; step();
    check("bound_x310", 32'(destroy), 0);
    e_x[3] = 311; step();
    check("bound_x311", 32'(destroy), 32'b01000);
    e_x[3] = 329; step();
    check("bound_x329", 32'(destroy), 32'b01000);
    e_x[3] = 330; step();
    check("bound_x330", 32'(destroy), 0);
    e_x[3] = 320; e_y[3] = 439; step();
    check("bound_y439", 32'(destroy), 0);
    e_y[3] = 461; step();
    check("bound_y461", 32'(destroy), 0);
    e_y[3] = 460; step();
    check("bound_y460", 32'(destroy), 32'b01000);
    clear_slots(); step();

    // Third hit with a shot in flight: game over.
    repeat (INVULN_CYCLES + 5) step();
    btn_fire = 1'b1; step();
    btn_fire = 1'b0;
    e_x[2] = 320; e_y[2] = 450; step();
    check("over_lives", 32'(lives), 0);
    check("over_flag", 32'(game_over), 1);
    btn_left = 1'b1; btn_fire = 1'b1;
    repeat (8) step();
    check("over_destroy", 32'(destroy), 0);
    check("over_frozen_x", 32'(player_x), 320);
    check("over_no_shot", 32'(projectiles_y), 0);
    check("over_sticky", 32'(game_over), 1);

    // Restart via play low for one cycle.
    play = 1'b0; step();
    check("restart_lives", 32'(lives), 3);
    check("restart_go", 32'(game_over), 0);
    check("restart_x", 32'(player_x), 320);
    play = 1'b1; btn_left = 1'b0; btn_fire = 1'b0;
    clear_slots();

    // Randomized play.
    for (int n = 0; n < 3000; n++) begin
      btn_left  = ($urandom_range(0, 3) == 0);
      btn_right = ($urandom_range(0, 2) == 0);
      btn_fire  = ($urandom_range(0, 3) == 0);
      collision = ($urandom_range(0, 7) == 0);
      play      = ($urandom_range(0, 199) != 0);
      for (int k = 0; k < 5; k++) begin
        r = int'($urandom_range(0, 15));
        if (r < 10) begin
          e_y[k] = 0;
          e_x[k] = int'($urandom_range(0, 511));
        end else if (r < 12) begin
          e_y[k] = int'($urandom_range(435, 465));
          e_x[k] = m_px + int'($urandom_range(0, 30)) - 15;
        end else begin
          e_y[k] = int'($urandom_range(1, 511));
          e_x[k] = int'($urandom_range(0, 1023));
        end
        if (e_x[k] < 0) e_x[k] = 0;
        if (k < 4 && e_x[k] > 511) e_x[k] = 511;
      end
      step();
    end

    // Asynchronous clear between edges.
    play = 1'b1; btn_fire = 1'b0; collision = 1'b0;
    clear_slots();
    btn_right = 1'b1;
    repeat (12) step();
    btn_fire = 1'b1; step();
    clr = 1'b1;
    #2;
    check("async_clr_x", 32'(player_x), 320);
    check("async_clr_lives", 32'(lives), 3);
    check("async_clr_shot", 32'(projectiles_y), 0);
    check("async_clr_go", 32'(game_over), 0);
    model_reinit();
    clr = 1'b0; btn_fire = 1'b0; btn_right = 1'b0;
    repeat (5) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
